// File: rtl/msrv32_imem_responder.sv
// Instruction-memory responder for the msrv32 PC unit.
// Accepts a fetch address in the address phase, inserts WAIT_STATES ready-low
// cycles, then returns the instruction word (or NOP with err on a bad fetch)
// in a one-cycle data phase. A side write port loads the program.
// Optional build macro: MSRV32_IMEM_STALL_CNT_EN adds stall_count_out.
module msrv32_imem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned WAIT_STATES  = 1,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] iaddr_in,
  input  logic        req_in,
  output logic        ahb_ready_out,
  output logic [31:0] instr_out,
  output logic        instr_valid_out,
  output logic        err_out,
  input  logic        wr_en_in,
  input  logic [31:0] wr_addr_in,
  input  logic [31:0] wr_data_in
`ifdef MSRV32_IMEM_STALL_CNT_EN
  ,
  output logic [15:0] stall_count_out
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt_q, cnt_nxt;
  logic [AW-1:0]  idx_q, idx_nxt;
  logic           bad_q, bad_nxt;
  logic           ready_nxt, valid_nxt, err_nxt;
  logic [31:0]    instr_nxt;

  logic [31:0]    mem [DEPTH_WORDS];

  logic [31:0]    req_off, wr_off;
  logic [AW-1:0]  req_idx, wr_idx;
  logic           req_bad, wr_ok, accept;

  // Address decode for the fetch and program-load ports (offsets wrap below base)
  assign req_off = iaddr_in - BASE_ADDRESS;
  assign wr_off  = wr_addr_in - BASE_ADDRESS;
  assign req_idx = req_off[AW+1:2];
  assign wr_idx  = wr_off[AW+1:2];
  assign req_bad = (iaddr_in[1:0] != 2'b00) || ((req_off >> 2) >= DEPTH_WORDS);
  assign wr_ok   = wr_en_in && ((wr_off >> 2) < DEPTH_WORDS);
  assign accept  = ahb_ready_out && req_in;

  // Next state, wait counter, latched fetch and next registered outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    bad_nxt   = bad_q;
    ready_nxt = 1'b1;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    instr_nxt = instr_out;

    case (state)
      IDLE, DATA: begin
        if (accept) begin
          idx_nxt = req_idx;
          bad_nxt = req_bad;
          if (WAIT_STATES == 0) begin
            state_nxt = DATA;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CW'(WAIT_STATES - 1);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_nxt = DATA;
        else             cnt_nxt   = cnt_q - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt = (state_nxt != WAIT);

    // Data phase read; a write landing in the cycle before DATA is forwarded
    if (state_nxt == DATA) begin
      valid_nxt = 1'b1;
      err_nxt   = bad_nxt;
      if (bad_nxt)                          instr_nxt = NOP_INSTR;
      else if (wr_ok && (wr_idx == idx_nxt)) instr_nxt = wr_data_in;
      else                                  instr_nxt = mem[idx_nxt];
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      bad_q           <= 1'b0;
      ahb_ready_out   <= 1'b1;
      instr_out       <= NOP_INSTR;
      instr_valid_out <= 1'b0;
      err_out         <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt_q           <= cnt_nxt;
      idx_q           <= idx_nxt;
      bad_q           <= bad_nxt;
      ahb_ready_out   <= ready_nxt;
      instr_out       <= instr_nxt;
      instr_valid_out <= valid_nxt;
      err_out         <= err_nxt;
    end
  end

  // Program-load write port; contents are not reset
  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wr_idx] <= wr_data_in;
  end

`ifdef MSRV32_IMEM_STALL_CNT_EN
  // Saturating count of ready-low cycles
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_count_out <= '0;
    end else if (!ahb_ready_out && (stall_count_out != 16'hFFFF)) begin
      stall_count_out <= stall_count_out + 16'd1;
    end
  end
`endif

endmodule
